// File: rtl/regfile_operand_pkg.sv
// rtl/regfile_operand_pkg.sv - shared sizes and PSR bit positions for the operand stage
//
// Purpose: default datapath/register-file sizes and the bit index of each
//          processor status flag inside the 5-bit PSR vector {C,L,F,Z,N}.
// Ports:   none (package).
package regfile_operand_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = $clog2(NREG);

  localparam int PSR_W  = 5;
  localparam int PSR_C  = 4;  // carry
  localparam int PSR_L  = 3;  // less-than, from comparator
  localparam int PSR_F  = 2;  // flag
  localparam int PSR_Z  = 1;  // zero, from comparator
  localparam int PSR_N  = 0;  // negative

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - NREG x DATA_W register array, 2 async reads, 1 sync write
//
// Purpose: plain storage for the operand stage; R0 is an ordinary register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low clear of every register
//   rdAddrA / rdDataA   read port A (combinational)
//   rdAddrB / rdDataB   read port B (combinational)
//   wrEn, wrAddr,
//   wrData              write port, captured on the rising edge
module regfile_core #(
  parameter int DATA_W = regfile_operand_pkg::DATA_W,
  parameter int NREG   = regfile_operand_pkg::NREG,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/regfile_operand.sv
// rtl/regfile_operand.sv - operand fetch stage: register file, write-back bypass, handshake, PSR
//
// Purpose: captures ALU operands from the register file (or the immediate) into an
//          output register guarded by a valid/ready handshake, and keeps the PSR.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            request handshake from decode
//   src_addr, dst_addr             operand A / operand B register indices
//   imm_sel, imm_in                select the immediate as operand A
//   op_a, op_b, op_dst, out_valid  registered operands toward the ALU
//   out_ready                      ALU consumes the operands
//   wr_en, wr_addr, wr_data        write-back port
//   flag_in, flag_we, psr          {C,L,F,Z,N} flags, per-bit write mask, status register
module regfile_operand #(
  parameter int DATA_W = regfile_operand_pkg::DATA_W,
  parameter int NREG   = regfile_operand_pkg::NREG,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ADDR_W-1:0]                   src_addr,
  input  logic [ADDR_W-1:0]                   dst_addr,
  input  logic                                imm_sel,
  input  logic [DATA_W-1:0]                   imm_in,
  output logic [DATA_W-1:0]                   op_a,
  output logic [DATA_W-1:0]                   op_b,
  output logic [ADDR_W-1:0]                   op_dst,
  output logic                                out_valid,
  input  logic                                out_ready,
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [regfile_operand_pkg::PSR_W-1:0] flag_in,
  input  logic [regfile_operand_pkg::PSR_W-1:0] flag_we,
  output logic [regfile_operand_pkg::PSR_W-1:0] psr
);

  import regfile_operand_pkg::*;

  logic [DATA_W-1:0] regRdA;
  logic [DATA_W-1:0] regRdB;
  logic [DATA_W-1:0] nextA;
  logic [DATA_W-1:0] nextB;
  logic [PSR_W-1:0]  psrReg;

  regfile_core #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) uCore (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdAddrA (src_addr),
    .rdDataA (regRdA),
    .rdAddrB (dst_addr),
    .rdDataB (regRdB),
    .wrEn    (wr_en),
    .wrAddr  (wr_addr),
    .wrData  (wr_data)
  );

  // A same-cycle write-back is not yet visible in the array, so forward it.
  // The immediate wins over forwarding for operand A.
  always_comb begin
    nextA = regRdA;
    nextB = regRdB;
    if (imm_sel) begin
      nextA = imm_in;
    end else if (wr_en && (wr_addr == src_addr)) begin
      nextA = wr_data;
    end
    if (wr_en && (wr_addr == dst_addr)) begin
      nextB = wr_data;
    end
  end

  assign in_ready = !out_valid || out_ready;

  // Output register only moves when the slot is free or being drained; during a
  // stall it holds, even if the held source register is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_dst    <= '0;
      out_valid <= 1'b0;
    end else if (in_ready) begin
      if (in_valid) begin
        op_a      <= nextA;
        op_b      <= nextB;
        op_dst    <= dst_addr;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Each flag updates on its own mask bit every cycle, regardless of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psrReg <= '0;
    end else begin
      if (flag_we[PSR_C]) psrReg[PSR_C] <= flag_in[PSR_C];
      if (flag_we[PSR_L]) psrReg[PSR_L] <= flag_in[PSR_L];
      if (flag_we[PSR_F]) psrReg[PSR_F] <= flag_in[PSR_F];
      if (flag_we[PSR_Z]) psrReg[PSR_Z] <= flag_in[PSR_Z];
      if (flag_we[PSR_N]) psrReg[PSR_N] <= flag_in[PSR_N];
    end
  end

  assign psr = psrReg;

endmodule

// File: tb/tb_regfile_operand.sv
// tb/tb_regfile_operand.sv - directed self-checking bench for regfile_operand
module tb_regfile_operand;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  src_addr;
  logic [3:0]  dst_addr;
  logic        imm_sel;
  logic [15:0] imm_in;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_dst;
  logic        out_valid;
  logic        out_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  flag_in;
  logic [4:0]  flag_we;
  logic [4:0]  psr;

  int passCnt  = 0;
  int totalCnt = 0;

  regfile_operand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .imm_sel   (imm_sel),
    .imm_in    (imm_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_dst    (op_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flag_in   (flag_in),
    .flag_we   (flag_we),
    .psr       (psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; src_addr = 4'd0; dst_addr = 4'd0;
    imm_sel = 1'b0; imm_in = 16'h0; out_ready = 1'b1; wr_en = 1'b0;
    wr_addr = 4'd0; wr_data = 16'h0; flag_in = 5'b0; flag_we = 5'b0;
    #12;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passCnt++;
    totalCnt++; if (op_a !== 16'h0) $display("FAIL reset_op_a got %h want 0000", op_a); else passCnt++;
    totalCnt++; if (op_b !== 16'h0) $display("FAIL reset_op_b got %h want 0000", op_b); else passCnt++;
    totalCnt++; if (op_dst !== 4'h0) $display("FAIL reset_op_dst got %h want 0", op_dst); else passCnt++;
    totalCnt++; if (psr !== 5'b0) $display("FAIL reset_psr got %b want 00000", psr); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passCnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    in_valid = 1'b1; src_addr = 4'd3; dst_addr = 4'd3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    totalCnt++; if (op_a !== 16'h1234) $display("FAIL wr_rd_op_a got %h want 1234", op_a); else passCnt++;
    totalCnt++; if (op_b !== 16'h1234) $display("FAIL wr_rd_op_b got %h want 1234", op_b); else passCnt++;
    totalCnt++; if (op_dst !== 4'd3) $display("FAIL wr_rd_op_dst got %h want 3", op_dst); else passCnt++;
    totalCnt++; if (out_valid !== 1'b1) $display("FAIL wr_rd_out_valid got %b want 1", out_valid); else passCnt++;
    step();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL drain_out_valid got %b want 0", out_valid); else passCnt++;
  endtask

  task automatic test_bypass_back_to_back();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1111;
    step();
    wr_data = 16'hBEEF;
    in_valid = 1'b1; src_addr = 4'd5; dst_addr = 4'd3;
    step();
    totalCnt++; if (op_a !== 16'hBEEF) $display("FAIL bypass_a got %h want beef", op_a); else passCnt++;
    totalCnt++; if (op_b !== 16'h1234) $display("FAIL bypass_a_op_b got %h want 1234", op_b); else passCnt++;
    // Second request back-to-back, forwarding onto operand B this time.
    wr_addr = 4'd7; wr_data = 16'h7777; src_addr = 4'd3; dst_addr = 4'd7;
    #1;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %b want 1", in_ready); else passCnt++;
    step();
    totalCnt++; if (out_valid !== 1'b1) $display("FAIL b2b_out_valid got %b want 1", out_valid); else passCnt++;
    totalCnt++; if (op_a !== 16'h1234) $display("FAIL b2b_op_a got %h want 1234", op_a); else passCnt++;
    totalCnt++; if (op_b !== 16'h7777) $display("FAIL bypass_b got %h want 7777", op_b); else passCnt++;
    totalCnt++; if (op_dst !== 4'd7) $display("FAIL b2b_op_dst got %h want 7", op_dst); else passCnt++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; src_addr = 4'd5; dst_addr = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      #1;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); else passCnt++;
      step();
      totalCnt++;
      if (op_a !== 16'h1234 || op_b !== 16'h7777 || op_dst !== 4'd7 || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d] got a=%h b=%h dst=%h v=%b want a=1234 b=7777 dst=7 v=1",
                 i, op_a, op_b, op_dst, out_valid);
      else passCnt++;
    end
    wr_en = 1'b0; out_ready = 1'b1;
    #1;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else passCnt++;
    step();
    totalCnt++;
    if (op_a !== 16'hBEEF || op_b !== 16'hBEEF || op_dst !== 4'd5 || out_valid !== 1'b1)
      $display("FAIL release_load got a=%h b=%h dst=%h v=%b want a=beef b=beef dst=5 v=1",
               op_a, op_b, op_dst, out_valid);
    else passCnt++;
  endtask

  task automatic test_imm();
    in_valid = 1'b1; src_addr = 4'd5; dst_addr = 4'd7; imm_sel = 1'b1; imm_in = 16'hFFF0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
    step();
    totalCnt++; if (op_a !== 16'hFFF0) $display("FAIL imm_op_a got %h want fff0", op_a); else passCnt++;
    totalCnt++; if (op_b !== 16'h9999) $display("FAIL stall_write_landed got %h want 9999", op_b); else passCnt++;
    in_valid = 1'b0; imm_sel = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_psr();
    flag_in = 5'b11111; flag_we = 5'b01010;
    step();
    totalCnt++; if (psr !== 5'b01010) $display("FAIL psr_masked got %b want 01010", psr); else passCnt++;
    flag_in = 5'b00000; flag_we = 5'b00000;
    step();
    totalCnt++; if (psr !== 5'b01010) $display("FAIL psr_hold got %b want 01010", psr); else passCnt++;
    flag_in = 5'b10101; flag_we = 5'b11111;
    step();
    totalCnt++; if (psr !== 5'b10101) $display("FAIL psr_full got %b want 10101", psr); else passCnt++;
    flag_in = 5'b11111;
    step();
    flag_we = 5'b00000;
    totalCnt++; if (psr !== 5'b11111) $display("FAIL psr_ones got %b want 11111", psr); else passCnt++;
    totalCnt++; if (out_valid !== 1'b1) $display("FAIL psr_indep_out_valid got %b want 1", out_valid); else passCnt++;
  endtask

  task automatic test_reset_mid();
    src_addr = 4'd3;
    #2;
    rst_n = 1'b0;
    #1;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL async_out_valid got %b want 0", out_valid); else passCnt++;
    totalCnt++; if (psr !== 5'b0) $display("FAIL async_psr got %b want 00000", psr); else passCnt++;
    totalCnt++; if (op_a !== 16'h0) $display("FAIL async_op_a got %h want 0000", op_a); else passCnt++;
    totalCnt++; if (dut.regRdA !== 16'h0) $display("FAIL async_r3 got %h want 0000", dut.regRdA); else passCnt++;
    #3;
    rst_n = 1'b1;
    in_valid = 1'b1; src_addr = 4'd3; dst_addr = 4'd5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    totalCnt++;
    if (op_a !== 16'h0 || op_b !== 16'h0 || op_dst !== 4'd5 || out_valid !== 1'b1)
      $display("FAIL post_reset_load got a=%h b=%h dst=%h v=%b want a=0000 b=0000 dst=5 v=1",
               op_a, op_b, op_dst, out_valid);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass_back_to_back();
    test_stall();
    test_imm();
    test_psr();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/regfile_operand.md
REGFILE_OPERAND -- requirements
Module: regfile_operand

Interface
REQ-001 Parameter DATA_W, default 16, datapath width in bits.
REQ-002 Parameter NREG, default 16, register count; address width is log2(NREG), which is 4 at the default.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  decode stage presents an operand request.
REQ-006 in_ready  out  1  block accepts the request this cycle.
REQ-007 src_addr  in  4  source register index, giving operand A.
REQ-008 dst_addr  in  4  destination register index, giving operand B.
REQ-009 imm_sel  in  1  1 = replace operand A with imm_in.
REQ-010 imm_in  in  DATA_W  sign-extended immediate.
REQ-011 op_a  out  DATA_W  registered source operand to the ALU.
REQ-012 op_b  out  DATA_W  registered destination operand to the ALU.
REQ-013 op_dst  out  4  registered dst_addr, carried for write-back.
REQ-014 out_valid  out  1  op_a, op_b and op_dst are valid.
REQ-015 out_ready  in  1  ALU consumes the operands this cycle.
REQ-016 wr_en  in  1  write-back strobe from the ALU result.
REQ-017 wr_addr  in  4  write-back register index.
REQ-018 wr_data  in  DATA_W  write-back value.
REQ-019 flag_in  in  5  ALU flags {C,L,F,Z,N}, with L and Z taken from the comparator.
REQ-020 flag_we  in  5  per-bit write mask for the PSR.
REQ-021 psr  out  5  current processor status flags {C,L,F,Z,N}.

Function
REQ-022 Register file SHALL hold NREG x DATA_W registers; R0 is an ordinary register, not hardwired.
REQ-023 Write SHALL occur on the clock edge when wr_en=1: reg[wr_addr] <= wr_data.
REQ-024 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-025 On in_valid && in_ready, op_a SHALL load (imm_sel ? imm_in : reg[src_addr]), op_b SHALL load reg[dst_addr], op_dst SHALL load dst_addr, and out_valid SHALL become 1, all with 1-cycle latency.
REQ-026 Bypass: when wr_en=1 and wr_addr equals a read address in the same cycle, the captured operand SHALL be wr_data, not the stale register value.
REQ-027 The bypass SHALL be suppressed for operand A when imm_sel=1.
REQ-028 When out_valid && out_ready && !in_valid, out_valid SHALL clear on the next edge.
REQ-029 When out_valid && out_ready && in_valid, the next request SHALL load back-to-back with out_valid held at 1 and no bubble.
REQ-030 Stall: when out_valid && !out_ready, op_a, op_b, op_dst and out_valid SHALL hold unchanged, and in_ready SHALL be 0.
REQ-031 Held operands SHALL NOT be refreshed by write-back during a stall; hazard handling during a stall belongs to the issuing stage.
REQ-032 PSR update SHALL occur on every edge: for each bit i, if flag_we[i]=1 then psr[i] <= flag_in[i], otherwise hold.
REQ-033 PSR update SHALL be independent of the operand handshake.
REQ-034 psr SHALL be driven directly from the flag register, with no combinational path from flag_in.

Reset
REQ-035 While rst_n=0, all NREG registers, op_a, op_b, op_dst, out_valid and psr SHALL be 0, asynchronously.
REQ-036 Reset applied mid-transfer SHALL discard the pending operand with out_valid=0; there is no replay.
REQ-037 The first edge after rst_n deasserts SHALL behave as a normal cycle.

Structure
REQ-038 The shared package SHALL contain DATA_W, NREG, the register-address width, and the PSR bit-index constants C=4, L=3, F=2, Z=1, N=0.
REQ-039 The register array SHALL be one sub-module, regfile_core: 2 asynchronous read ports and 1 synchronous write port.
REQ-040 The bypass mux, the handshake logic and the PSR SHALL sit in regfile_operand.

Verification
REQ-041 Reset, then write R3=0x1234, then request src=3, dst=3 -> next cycle op_a=op_b=0x1234, out_valid=1.
REQ-042 Same-cycle wr_en to R5=0xBEEF with request src=5 -> op_a=0xBEEF, not the old value.
REQ-043 out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0, operands unchanged; out_ready=1 -> next request loads.
REQ-044 imm_sel=1, imm_in=0xFFF0, with a write to src_addr in the same cycle -> op_a=0xFFF0.
REQ-045 psr=00000, flag_in=11111, flag_we=01010 -> psr=01010; then flag_we=0 -> psr held.
REQ-046 rst_n pulled low while out_valid=1 and psr=11111 -> out_valid=0, psr=0, R3 reads 0, all immediately without waiting for a clock edge.
